eth_pkt_tx: RTL and testbench
=============================

Name: eth_pkt_tx

Overview:
Packet transmitter that produces the switch ingress stream: 64-bit data words qualified by vld, with inSop and inEop framing.
- Accepts a packet command (destination address, source address, payload length) and a separate stream of payload words.
- Buffers payload store-and-forward in an internal FIFO, so every emitted packet is contiguous (vld never drops between inSop and inEop).
- Sits in front of the switch ingress port; the switch-side monitor sees its output directly.

Parameters:
- DEPTH, 16, payload FIFO depth in 64-bit words; also the maximum legal payload length.
- LEN_W, $clog2(DEPTH+1), width of the length field.
- IPG, 2, idle cycles forced after each inEop (0 is legal).

Ports:
- clk  in  1  clock, all logic rising-edge.
- resetN  in  1  asynchronous active-low reset.
- cmd_valid  in  1  packet command valid.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_da  in  32  destination address.
- cmd_sa  in  32  source address.
- cmd_len  in  LEN_W  payload words (0..DEPTH).
- pl_valid  in  1  payload word valid.
- pl_ready  out  1  FIFO can accept a word.
- pl_data  in  64  payload word.
- inData  out  64  switch ingress data.
- inSop  out  1  first word of packet.
- inEop  out  1  last word of packet.
- vld  out  1  inData valid.
- busy  out  1  state != IDLE.
- err_len  out  1  one-cycle pulse: command rejected.
- pkt_count  out  16  packets sent; wraps FFFF->0000.

Behaviour:
- Reset (async assert, sync release):
  - inData=0, inSop=0, inEop=0, vld=0, err_len=0, pkt_count=0, busy=0.
  - FIFO emptied; state IDLE.
- Packet format:
  - Word 0 is the header: inData[63:32]=DA, inData[31:0]=SA.
  - Followed by cmd_len payload words in FIFO order.
  - cmd_len=0 gives a single-word packet with inSop and inEop in the same cycle.
- Outputs inData, inSop, inEop and vld are registered.
- Payload side:
  - pl_ready = !full; a word is pushed on pl_valid && pl_ready.
  - Push and pop in the same cycle are legal; count is unchanged.
  - Payload words are not tied to a command; they are consumed strictly in order.
- cmd_ready = (state == IDLE).
- FSM states IDLE, WAIT, HDR, PAY, GAP:
  - IDLE: on accept with cmd_len > DEPTH: pulse err_len next cycle, stay IDLE, emit nothing. Otherwise latch DA, SA and len, go to WAIT.
  - WAIT: when the registered FIFO count >= len, go to HDR; otherwise hold. Words pushed in the same cycle do not count toward the comparison.
  - HDR: drive the header with vld=1 and inSop=1; inEop=1 if len==0. Then go to PAY (len>0), else GAP.
  - PAY: pop one word per cycle and drive it with vld=1. The remaining-word counter decrements; the last word carries inEop=1. Then go to GAP.
  - GAP: vld=0 for IPG cycles, then IDLE. With IPG=0, go directly to IDLE.
- Latency:
  - Payload fully buffered at accept cycle T: WAIT at T+1, header on outputs at T+2 (inSop high in that cycle).
  - Payload words follow at T+3 .. T+2+len.
- pkt_count increments in the cycle inEop is driven.
- vld=0 forces inSop=0, inEop=0 and inData=0.
- A full FIFO holding fewer words than len cannot occur, because len <= DEPTH.
- Reset mid-packet: outputs drop immediately, the packet is truncated without inEop, and buffered payload is discarded. Downstream must tolerate this.

Decomposition:
- Package eth_sw_pkg holds:
  - header bit positions (DA_MSB=63, DA_LSB=32, SA_MSB=31, SA_LSB=0);
  - state enum tx_state_e {IDLE, WAIT, HDR, PAY, GAP};
  - data width constant DATA_W=64.
- One sub-module, eth_tx_fifo:
  - synchronous FIFO, DEPTH x 64, first-word-fall-through read;
  - ports push, pop, full, empty and count[LEN_W-1:0].

Test Plan:
- Push 3 words A1..A3, then command DA=0x0A0B0C0D, SA=0x11223344, len=3 accepted at T -> header 0x0A0B0C0D11223344 with inSop at T+2; A1, A2, A3 at T+3..T+5; inEop at T+5; vld low T+6..T+7; pkt_count=1.
- Command len=2 with no payload, then push 1 word, wait 5 cycles, push a 2nd -> no vld while short; header 2 cycles after 2nd push, contiguous 3-word packet.
- len=0 command -> one cycle with vld=inSop=inEop=1 and header data; pkt_count+1.
- cmd_len=DEPTH+1 -> cmd_ready stays high, err_len pulses once, vld never asserted, FIFO count unchanged.
- Fill FIFO to DEPTH -> pl_ready=0. Then send len=DEPTH: pl_ready rises the cycle after the first pop; the 17th word pushed during PAY is preserved for the next packet.
- Assert resetN=0 mid-PAY -> vld, inSop, inEop and pkt_count go to 0 without waiting for a clock edge; after release, busy=0, pl_ready=1 and FIFO is empty.

Source files
------------

// File: rtl/eth_sw_pkg.sv
// eth_sw_pkg: shared constants and types for the switch ingress transmitter.
package eth_sw_pkg;
    localparam int DATA_W = 64;
    localparam int DA_MSB = 63;
    localparam int DA_LSB = 32;
    localparam int SA_MSB = 31;
    localparam int SA_LSB = 0;
    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        HDR,
        PAY,
        GAP
    } tx_state_e;
endpackage

// File: rtl/eth_tx_fifo.sv
// eth_tx_fifo: synchronous first-word-fall-through payload FIFO.
module eth_tx_fifo import eth_sw_pkg::*; #(
    parameter int DEPTH = 16,
    parameter int LEN_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic [LEN_W-1:0]  count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [LEN_W-1:0]  count_q, count_d;
    logic              do_push, do_pop;
    always_comb begin
        do_push = push && !full;
        do_pop  = pop && !empty;
        wr_d    = do_push ? ((wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + 1'b1) : wr_q;
        rd_d    = do_pop ? ((rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + 1'b1) : rd_q;
        count_d = count_q + LEN_W'(do_push) - LEN_W'(do_pop);
    end
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end
    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata;
    end
    assign rdata = mem_q[rd_q];
    assign full  = (count_q == LEN_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
endmodule

// File: rtl/eth_pkt_tx.sv
// eth_pkt_tx: store-and-forward packet transmitter feeding the switch ingress port.
// Emits a {DA,SA} header word then the buffered payload, followed by a forced idle gap.
module eth_pkt_tx import eth_sw_pkg::*; #(
    parameter int DEPTH = 16,
    parameter int LEN_W = $clog2(DEPTH + 1),
    parameter int IPG   = 2
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [31:0]       cmd_da,
    input  logic [31:0]       cmd_sa,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              pl_valid,
    output logic              pl_ready,
    input  logic [DATA_W-1:0] pl_data,
    output logic [DATA_W-1:0] inData,
    output logic              inSop,
    output logic              inEop,
    output logic              vld,
    output logic              busy,
    output logic              err_len,
    output logic [15:0]       pkt_count
);
    localparam int GW = (IPG > 1) ? $clog2(IPG) : 1;
    localparam tx_state_e END_ST = (IPG == 0) ? IDLE : GAP;
    tx_state_e         state_q, state_d;
    logic [31:0]       da_q, da_d, sa_q, sa_d;
    logic [LEN_W-1:0]  len_q, len_d, rem_q, rem_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              sop_q, sop_d, eop_q, eop_d, vld_q, vld_d, err_q, err_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              pop, fifo_full, fifo_empty;
    logic [DATA_W-1:0] fifo_rdata;
    logic [LEN_W-1:0]  fifo_count;
    eth_tx_fifo #(.DEPTH(DEPTH), .LEN_W(LEN_W)) u_fifo (
        .clk    (clk),
        .resetN (resetN),
        .push   (pl_valid),
        .wdata  (pl_data),
        .pop    (pop),
        .rdata  (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );
    // Output registers are loaded from the transition into a state, so the
    // header is visible in the same cycle the state register reads HDR.
    always_comb begin
        state_d = state_q;
        da_d    = da_q;
        sa_d    = sa_q;
        len_d   = len_q;
        rem_d   = rem_q;
        gap_d   = gap_q;
        data_d  = '0;
        sop_d   = 1'b0;
        eop_d   = 1'b0;
        vld_d   = 1'b0;
        err_d   = 1'b0;
        pop     = 1'b0;
        case (state_q)
            IDLE: if (cmd_valid) begin
                if (cmd_len > LEN_W'(DEPTH)) begin
                    err_d = 1'b1;
                end else begin
                    da_d    = cmd_da;
                    sa_d    = cmd_sa;
                    len_d   = cmd_len;
                    state_d = WAIT;
                end
            end
            WAIT: if (fifo_count >= len_q) begin
                vld_d                  = 1'b1;
                sop_d                  = 1'b1;
                eop_d                  = (len_q == '0);
                data_d[DA_MSB:DA_LSB]  = da_q;
                data_d[SA_MSB:SA_LSB]  = sa_q;
                rem_d                  = len_q;
                state_d                = HDR;
            end
            HDR, PAY: begin
                gap_d = '0;
                if (rem_q == '0) begin
                    state_d = END_ST;
                end else if (!fifo_empty) begin
                    pop     = 1'b1;
                    vld_d   = 1'b1;
                    data_d  = fifo_rdata;
                    eop_d   = (rem_q == LEN_W'(1));
                    rem_d   = rem_q - 1'b1;
                    state_d = eop_d ? END_ST : PAY;
                end
            end
            GAP: begin
                gap_d   = gap_q + 1'b1;
                state_d = (int'(gap_q) + 1 >= IPG) ? IDLE : GAP;
            end
            default: state_d = IDLE;
        endcase
        cnt_d = eop_d ? cnt_q + 16'd1 : cnt_q;
    end
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
            da_q    <= '0;
            sa_q    <= '0;
            len_q   <= '0;
            rem_q   <= '0;
            gap_q   <= '0;
            data_q  <= '0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            da_q    <= da_d;
            sa_q    <= sa_d;
            len_q   <= len_d;
            rem_q   <= rem_d;
            gap_q   <= gap_d;
            data_q  <= data_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end
    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign pl_ready  = !fifo_full;
    assign inData    = data_q;
    assign inSop     = sop_q;
    assign inEop     = eop_q;
    assign vld       = vld_q;
    assign err_len   = err_q;
    assign pkt_count = cnt_q;
endmodule

// File: tb/tb_eth_pkt_tx.sv
// tb_eth_pkt_tx: directed, table-driven bench for the switch ingress transmitter.
module tb_eth_pkt_tx;
    import eth_sw_pkg::*;
    localparam int DEPTH = 16;
    localparam int LEN_W = $clog2(DEPTH + 1);
    typedef struct {
        logic [31:0]      da;
        logic [31:0]      sa;
        logic [LEN_W-1:0] len;
        bit               err;
    } vec_t;
    logic              clk = 1'b0;
    logic              resetN = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [31:0]       cmd_da = '0;
    logic [31:0]       cmd_sa = '0;
    logic [LEN_W-1:0]  cmd_len = '0;
    logic              pl_valid = 1'b0;
    logic              pl_ready;
    logic [63:0]       pl_data = '0;
    logic [63:0]       inData;
    logic              inSop, inEop, vld, busy, err_len;
    logic [15:0]       pkt_count;
    vec_t              vecs[5];
    logic [63:0]       model_q[$];
    logic [15:0]       exp_pkts = '0;
    int                checks = 0;
    int                errors = 0;

    eth_pkt_tx #(.DEPTH(DEPTH), .LEN_W(LEN_W), .IPG(2)) dut (
        .clk       (clk),
        .resetN    (resetN),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_da    (cmd_da),
        .cmd_sa    (cmd_sa),
        .cmd_len   (cmd_len),
        .pl_valid  (pl_valid),
        .pl_ready  (pl_ready),
        .pl_data   (pl_data),
        .inData    (inData),
        .inSop     (inSop),
        .inEop     (inEop),
        .vld       (vld),
        .busy      (busy),
        .err_len   (err_len),
        .pkt_count (pkt_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [63:0] w);
        pl_valid = 1'b1;
        pl_data  = w;
        model_q.push_back(w);
        step();
        pl_valid = 1'b0;
    endtask

    // Leaves the bench sampling in the cycle after acceptance (T+1).
    task automatic send_cmd(input logic [31:0] da, input logic [31:0] sa, input logic [LEN_W-1:0] len);
        cmd_valid = 1'b1;
        cmd_da    = da;
        cmd_sa    = sa;
        cmd_len   = len;
        check("cmd_ready", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 8 && busy; i++) step();
        check("idle_busy", busy, 0);
        check("idle_cmd_ready", cmd_ready, 1);
    endtask

    // push_at > 0: push one extra word in that payload cycle, which must see pl_ready high.
    task automatic expect_pkt(input logic [31:0] da, input logic [31:0] sa, input logic [LEN_W-1:0] len, input int push_at);
        logic [63:0] w;
        step();
        check("hdr_flags", {vld, inSop, inEop}, {2'b11, len == '0});
        check("hdr_data", inData, {da, sa});
        if (push_at > 0) check("hdr_pl_ready", pl_ready, 0);
        if (len == '0) begin
            exp_pkts++;
            check("pkt_count", pkt_count, exp_pkts);
        end
        for (int i = 1; i <= int'(len); i++) begin
            step();
            pl_valid = 1'b0;
            w = 64'hDEAD_DEAD_DEAD_DEAD;
            if (model_q.size() > 0) w = model_q.pop_front();
            check("pay_flags", {vld, inSop, inEop}, {2'b10, i == int'(len)});
            check("pay_data", inData, w);
            if (i == int'(len)) begin
                exp_pkts++;
                check("pkt_count", pkt_count, exp_pkts);
            end
            if (i == push_at) begin
                check("pay_pl_ready", pl_ready, 1);
                pl_valid = 1'b1;
                pl_data  = 64'h1717_1717_0000_0017;
                model_q.push_back(pl_data);
            end
        end
        pl_valid = 1'b0;
        repeat (2) begin
            step();
            check("gap_vld", vld, 0);
        end
        wait_idle();
    endtask

    initial begin
        vecs[0] = '{32'h0A0B0C0D, 32'h11223344, LEN_W'(3), 1'b0};
        vecs[1] = '{32'hDEADBEEF, 32'hCAFEF00D, LEN_W'(0), 1'b0};
        vecs[2] = '{32'h12345678, 32'h9ABCDEF0, LEN_W'(DEPTH + 1), 1'b1};
        vecs[3] = '{32'hFFFFFFFF, 32'h00000001, LEN_W'(1), 1'b0};
        vecs[4] = '{32'h00000000, 32'h80000000, LEN_W'(5), 1'b0};

        repeat (3) step();
        check("rst_vld", vld, 0);
        check("rst_sop_eop", {inSop, inEop}, 0);
        check("rst_data", inData, 0);
        check("rst_err", err_len, 0);
        check("rst_pkt_count", pkt_count, 0);
        check("rst_busy", busy, 0);
        check("rst_pl_ready", pl_ready, 1);
        #3 resetN = 1'b1;
        step();

        for (int r = 0; r < 5; r++) begin
            if (vecs[r].err) begin
                send_cmd(vecs[r].da, vecs[r].sa, vecs[r].len);
                check("err_pulse", err_len, 1);
                check("err_busy", busy, 0);
                check("err_cmd_ready", cmd_ready, 1);
                step();
                check("err_pulse_end", err_len, 0);
                repeat (3) begin
                    step();
                    check("err_vld", vld, 0);
                end
            end else begin
                for (int i = 0; i < int'(vecs[r].len); i++)
                    push({32'hA5A5_0000 + 32'(r), 32'(i)});
                send_cmd(vecs[r].da, vecs[r].sa, vecs[r].len);
                expect_pkt(vecs[r].da, vecs[r].sa, vecs[r].len, 0);
            end
        end

        // Command arrives before its payload: nothing may be emitted while short.
        send_cmd(32'h5555AAAA, 32'h0F0F0F0F, LEN_W'(2));
        push(64'h0123_4567_89AB_CDEF);
        repeat (5) begin
            step();
            check("short_vld", vld, 0);
        end
        push(64'hFEDC_BA98_7654_3210);
        check("short_vld_after_push", vld, 0);
        expect_pkt(32'h5555AAAA, 32'h0F0F0F0F, LEN_W'(2), 0);

        // Fill to DEPTH, drain a full-length packet, and slip one extra word in.
        for (int i = 0; i < DEPTH; i++) push({32'hF111_0000, 32'(i)});
        check("full_pl_ready", pl_ready, 0);
        send_cmd(32'h00C0FFEE, 32'hBEEF0000, LEN_W'(DEPTH));
        check("full_pl_ready_t1", pl_ready, 0);
        expect_pkt(32'h00C0FFEE, 32'hBEEF0000, LEN_W'(DEPTH), 1);
        send_cmd(32'h17171717, 32'h71717171, LEN_W'(1));
        expect_pkt(32'h17171717, 32'h71717171, LEN_W'(1), 0);

        // Reset in the middle of a payload.
        for (int i = 0; i < 4; i++) push({32'hBBBB_0000, 32'(i)});
        send_cmd(32'h44444444, 32'h33333333, LEN_W'(4));
        repeat (3) step();
        check("pre_rst_vld", vld, 1);
        #2 resetN = 1'b0;
        #1;
        check("async_rst_vld", vld, 0);
        check("async_rst_flags", {inSop, inEop}, 0);
        check("async_rst_data", inData, 0);
        check("async_rst_pkt_count", pkt_count, 0);
        model_q.delete();
        exp_pkts = '0;
        #3 resetN = 1'b1;
        step();
        check("post_rst_busy", busy, 0);
        check("post_rst_pl_ready", pl_ready, 1);
        send_cmd(32'h99999999, 32'h88888888, LEN_W'(1));
        repeat (4) begin
            step();
            check("post_rst_empty_vld", vld, 0);
        end
        push(64'h0BAD_F00D_0000_0001);
        expect_pkt(32'h99999999, 32'h88888888, LEN_W'(1), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
